shifter: RTL and testbench
==========================

Name: shifter

Overview:
- 32-bit barrel shifter for the ARM32 CPU execute stage. Supports LSL, LSR, ASR and ROR by a 32-bit register-specified amount, using ARM register-shift semantics.
- Produces a combinational result and shifter carry-out for the same-cycle ALU operand path.
- Also keeps a registered copy of both for pipelined consumers.

Parameters:
- None. Data width is fixed at 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- shift_in  input  32  operand to shift
- shift_op  input  2  00=LSL, 01=LSR, 10=ASR, 11=ROR
- shift_amt  input  32  shift amount; the full 32-bit value is significant
- carry_in  input  1  current CPSR C flag, passed through when amount is 0
- en  input  1  capture enable for the registered outputs
- shift_out  output  32  combinational shift result
- carry_out  output  1  combinational shifter carry-out
- shift_out_q  output  32  registered shift_out
- carry_out_q  output  1  registered carry_out

Behaviour:
- Clocking and reset:
  - One clock domain (clk). Reset is synchronous and active-low (rst_n).
  - shift_out and carry_out are purely combinational, with zero latency. They are unaffected by clk and rst_n.
  - On posedge clk:
    - if rst_n=0: shift_out_q<=0 and carry_out_q<=0;
    - else if en=1: shift_out_q<=shift_out and carry_out_q<=carry_out;
    - else hold.
  - Reset takes priority over en. A reset asserted mid-stream clears the registers on that edge. The combinational path keeps tracking its inputs throughout.
- Let n = shift_amt (unsigned 32-bit). For every op, n=0 gives shift_out=shift_in and carry_out=carry_in.
- LSL:
  - 1<=n<=31: shift_out=shift_in<<n, zero-filled; carry=shift_in[32-n].
  - n=32: result 0; carry=shift_in[0].
  - n>32: result 0; carry 0.
- LSR:
  - 1<=n<=31: logical right shift, zero-filled; carry=shift_in[n-1].
  - n=32: result 0; carry=shift_in[31].
  - n>32: result 0; carry 0.
- ASR:
  - 1<=n<=31: arithmetic right shift, filled with shift_in[31]; carry=shift_in[n-1].
  - n>=32: every bit = shift_in[31]; carry=shift_in[31].
- ROR:
  - Let r = n[4:0].
  - n!=0 and r=0 (e.g. 32, 64): result=shift_in; carry=shift_in[31].
  - Otherwise: result = rotate right by r (bits leaving bit 0 re-enter at bit 31); carry=result[31].
- shift_op values are fully decoded. Inputs containing X produce X only on affected outputs; no latches.
- Implementation: a log-depth (5-stage mux) barrel structure or equivalent, plus the range detection for n>=32.

Test Plan:
- LSL by 1: shift_in=0xAAAAAAAA, op=00, amt=1 -> shift_out=0x55555554, carry_out=1.
- LSR by 1: shift_in=0xAAAAAAAA, op=01, amt=1 -> shift_out=0x55555555, carry_out=0.
- ASR by 1: shift_in=0xAAAAAAAA, op=10, amt=1 -> shift_out=0xD5555555, carry_out=0.
- ROR by 4: shift_in=0xAAAAAAAF, op=11, amt=4 -> shift_out=0xFAAAAAAA, carry_out=1.
- Boundaries, with shift_in=0x80000001 and carry_in=0:
  - LSL amt=32 -> 0, carry 1.
  - LSR amt=33 -> 0, carry 0.
  - ASR amt=40 -> 0xFFFFFFFF, carry 1.
  - ROR amt=32 -> 0x80000001, carry 1.
  - Any op amt=0 with carry_in=1 -> input unchanged, carry 1.
- Register path:
  - rst_n=0 over one posedge -> shift_out_q=0, carry_out_q=0.
  - Then en=1 with the ROR case above -> next edge shift_out_q=0xFAAAAAAA, carry_out_q=1.
  - en=0 with new inputs -> registered values hold.

Source files
------------

// File: rtl/shifter.sv
// rtl/shifter.sv - 32-bit ARM register-shift barrel shifter with registered copy
// Shifts LSL/LSR/ASR/ROR by a full 32-bit amount; combinational result plus pipelined copy.
module shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] shift_in,
  input  logic [1:0]  shift_op,
  input  logic [31:0] shift_amt,
  input  logic        carry_in,
  input  logic        en,
  output logic [31:0] shift_out,
  output logic        carry_out,
  output logic [31:0] shift_out_q,
  output logic        carry_out_q
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic [4:0]  amt_lo;
  logic        amt_zero;
  logic        amt_ge32;
  logic        amt_eq32;
  logic        fill;
  logic [31:0] sh_src;
  logic [32:0] s0, s1, s2, s3, s4, s5;
  logic [31:0] rs_res;
  logic        rs_carry;
  logic [31:0] t1, t2, t3, t4, t5;
  logic [31:0] shift_out_d;
  logic        carry_out_d;

  assign amt_lo   = shift_amt[4:0];
  assign amt_zero = (shift_amt == 32'd0);
  assign amt_ge32 = |shift_amt[31:5];
  assign amt_eq32 = (shift_amt == 32'd32);
  assign fill     = (shift_op == OP_ASR) & shift_in[31];

  // LSL reuses the right shifter on the bit-reversed operand; the extra LSB
  // catches the last bit shifted out, which is the carry for 1..31.
  assign sh_src = (shift_op == OP_LSL) ? bitrev(shift_in) : shift_in;
  assign s0 = {sh_src, 1'b0};
  assign s1 = amt_lo[0] ? {fill, s0[32:1]}          : s0;
  assign s2 = amt_lo[1] ? {{2{fill}}, s1[32:2]}     : s1;
  assign s3 = amt_lo[2] ? {{4{fill}}, s2[32:4]}     : s2;
  assign s4 = amt_lo[3] ? {{8{fill}}, s3[32:8]}     : s3;
  assign s5 = amt_lo[4] ? {{16{fill}}, s4[32:16]}   : s4;
  assign rs_res   = s5[32:1];
  assign rs_carry = s5[0];

  assign t1 = amt_lo[0] ? {shift_in[0],   shift_in[31:1]} : shift_in;
  assign t2 = amt_lo[1] ? {t1[1:0],  t1[31:2]}  : t1;
  assign t3 = amt_lo[2] ? {t2[3:0],  t2[31:4]}  : t2;
  assign t4 = amt_lo[3] ? {t3[7:0],  t3[31:8]}  : t3;
  assign t5 = amt_lo[4] ? {t4[15:0], t4[31:16]} : t4;

  always_comb begin
    shift_out = shift_in;
    carry_out = carry_in;
    if (!amt_zero) begin
      case (shift_op)
        OP_LSL: begin
          if (!amt_ge32) begin
            shift_out = bitrev(rs_res);
            carry_out = rs_carry;
          end else begin
            shift_out = 32'd0;
            carry_out = amt_eq32 & shift_in[0];
          end
        end
        OP_LSR: begin
          if (!amt_ge32) begin
            shift_out = rs_res;
            carry_out = rs_carry;
          end else begin
            shift_out = 32'd0;
            carry_out = amt_eq32 & shift_in[31];
          end
        end
        OP_ASR: begin
          if (!amt_ge32) begin
            shift_out = rs_res;
            carry_out = rs_carry;
          end else begin
            shift_out = {32{shift_in[31]}};
            carry_out = shift_in[31];
          end
        end
        OP_ROR: begin
          // A multiple of 32 leaves the value in place but still yields bit 31 as carry.
          shift_out = t5;
          carry_out = t5[31];
        end
        default: begin
          shift_out = 32'hxxxx_xxxx;
          carry_out = 1'bx;
        end
      endcase
    end
  end

  always_comb begin
    shift_out_d = en ? shift_out : shift_out_q;
    carry_out_d = en ? carry_out : carry_out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_out_q <= 32'd0;
      carry_out_q <= 1'b0;
    end else begin
      shift_out_q <= shift_out_d;
      carry_out_q <= carry_out_d;
    end
  end

endmodule

// File: tb/tb_shifter.sv
// tb/tb_shifter.sv - self-checking bench for shifter
// Directed cases plus randomized vectors against an arithmetic reference model.
module tb_shifter;

  logic        clk;
  logic        rst_n;
  logic [31:0] shift_in;
  logic [1:0]  shift_op;
  logic [31:0] shift_amt;
  logic        carry_in;
  logic        en;
  logic [31:0] shift_out;
  logic        carry_out;
  logic [31:0] shift_out_q;
  logic        carry_out_q;

  int n_cmp = 0;
  int n_bad = 0;

  shifter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_in    (shift_in),
    .shift_op    (shift_op),
    .shift_amt   (shift_amt),
    .carry_in    (carry_in),
    .en          (en),
    .shift_out   (shift_out),
    .carry_out   (carry_out),
    .shift_out_q (shift_out_q),
    .carry_out_q (carry_out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference built from wide arithmetic shifts rather than staged muxes.
  task automatic model(input logic [31:0] a, input logic [1:0] op, input logic [31:0] n,
                       input logic cin, output logic [31:0] res, output logic c);
    logic [63:0]        w;
    logic signed [63:0] sw;
    int                 k;
    if (n == 0) begin
      res = a;
      c   = cin;
    end else begin
      case (op)
        2'b00: begin
          if (n <= 32) begin
            w = {32'h0, a} << n;
            res = w[31:0];
            c   = w[32];
          end else begin
            res = 0;
            c   = 0;
          end
        end
        2'b01: begin
          if (n <= 32) begin
            w = {a, 32'h0} >> n;
            res = w[63:32];
            c   = w[31];
          end else begin
            res = 0;
            c   = 0;
          end
        end
        2'b10: begin
          k  = (n > 32) ? 32 : int'(n);
          sw = $signed({a, 32'h0}) >>> k;
          res = sw[63:32];
          c   = sw[31];
        end
        default: begin
          k = int'(n % 32);
          w = {a, a} >> k;
          res = w[31:0];
          c   = res[31];
        end
      endcase
    end
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [1:0] op,
                          input logic [31:0] n, input logic cin,
                          input logic [31:0] exp_res, input logic exp_c);
    shift_in  = a;
    shift_op  = op;
    shift_amt = n;
    carry_in  = cin;
    #1;
    chk({tag, "_res"}, shift_out, exp_res);
    chk({tag, "_c"}, {31'd0, carry_out}, {31'd0, exp_c});
  endtask

  logic [31:0] m_res;
  logic        m_c;
  logic [31:0] exp_q;
  logic        exp_cq;
  logic [31:0] amt_r;

  initial begin
    rst_n = 1'b0; en = 1'b0;
    shift_in = 32'h0; shift_op = 2'b00; shift_amt = 32'h0; carry_in = 1'b0;

    @(posedge clk); #1;
    chk("reset_q", shift_out_q, 32'h0);
    chk("reset_cq", {31'd0, carry_out_q}, 32'h0);

    directed("lsl1", 32'hAAAAAAAA, 2'b00, 32'd1, 1'b0, 32'h55555554, 1'b1);
    directed("lsr1", 32'hAAAAAAAA, 2'b01, 32'd1, 1'b0, 32'h55555555, 1'b0);
    directed("asr1", 32'hAAAAAAAA, 2'b10, 32'd1, 1'b0, 32'hD5555555, 1'b0);
    directed("ror4", 32'hAAAAAAAF, 2'b11, 32'd4, 1'b0, 32'hFAAAAAAA, 1'b1);
    directed("lsl32", 32'h80000001, 2'b00, 32'd32, 1'b0, 32'h0, 1'b1);
    directed("lsr33", 32'h80000001, 2'b01, 32'd33, 1'b0, 32'h0, 1'b0);
    directed("asr40", 32'h80000001, 2'b10, 32'd40, 1'b0, 32'hFFFFFFFF, 1'b1);
    directed("ror32", 32'h80000001, 2'b11, 32'd32, 1'b0, 32'h80000001, 1'b1);
    directed("lsl0", 32'h80000001, 2'b00, 32'd0, 1'b1, 32'h80000001, 1'b1);
    directed("lsr0", 32'h80000001, 2'b01, 32'd0, 1'b1, 32'h80000001, 1'b1);
    directed("asr0", 32'h80000001, 2'b10, 32'd0, 1'b1, 32'h80000001, 1'b1);
    directed("ror0", 32'h80000001, 2'b11, 32'd0, 1'b1, 32'h80000001, 1'b1);
    directed("lsr32", 32'h80000001, 2'b01, 32'd32, 1'b0, 32'h0, 1'b1);
    directed("lslbig", 32'hFFFFFFFF, 2'b00, 32'h80000000, 1'b1, 32'h0, 1'b0);

    // Register path: reset, capture, hold.
    rst_n = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    chk("rst_q", shift_out_q, 32'h0);
    chk("rst_cq", {31'd0, carry_out_q}, 32'h0);
    rst_n = 1'b1; en = 1'b1;
    shift_in = 32'hAAAAAAAF; shift_op = 2'b11; shift_amt = 32'd4; carry_in = 1'b0;
    @(posedge clk); #1;
    chk("cap_q", shift_out_q, 32'hFAAAAAAA);
    chk("cap_cq", {31'd0, carry_out_q}, 32'h1);
    en = 1'b0;
    shift_in = 32'h12345678; shift_op = 2'b00; shift_amt = 32'd3; carry_in = 1'b1;
    @(posedge clk); #1;
    chk("hold_q", shift_out_q, 32'hFAAAAAAA);
    chk("hold_cq", {31'd0, carry_out_q}, 32'h1);
    chk("hold_comb", shift_out, 32'h91A2B3C0);

    exp_q  = 32'hFAAAAAAA;
    exp_cq = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       amt_r = $urandom;
        1:       amt_r = 32'd32 * $urandom_range(0, 3);
        2:       amt_r = $urandom_range(30, 34);
        default: amt_r = $urandom_range(0, 40);
      endcase
      shift_in  = $urandom;
      shift_op  = 2'($urandom_range(0, 3));
      shift_amt = amt_r;
      carry_in  = 1'($urandom_range(0, 1));
      en        = 1'($urandom_range(0, 1));
      rst_n     = ($urandom_range(0, 15) != 0);
      #1;
      model(shift_in, shift_op, shift_amt, carry_in, m_res, m_c);
      chk("rnd_res", shift_out, m_res);
      chk("rnd_c", {31'd0, carry_out}, {31'd0, m_c});
      if (!rst_n) begin
        exp_q  = 32'h0;
        exp_cq = 1'b0;
      end else if (en) begin
        exp_q  = m_res;
        exp_cq = m_c;
      end
      @(posedge clk); #1;
      chk("rnd_q", shift_out_q, exp_q);
      chk("rnd_cq", {31'd0, carry_out_q}, {31'd0, exp_cq});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
